// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: byte-strobe write side plus serial line and status outputs
// of the buffered UART transmitter. The producer uses the master modport and
// the transmitter uses the slave modport.
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic               tx_send;
    logic [7:0]         tx_data;
    logic               uart_tx;
    logic               tx_busy;
    logic               tx_full;
    logic [LEVEL_W-1:0] fifo_level;
    logic               tx_overflow;

    modport master (
        output tx_send,
        output tx_data,
        input  uart_tx,
        input  tx_busy,
        input  tx_full,
        input  fifo_level,
        input  tx_overflow
    );

    modport slave (
        input  tx_send,
        input  tx_data,
        output uart_tx,
        output tx_busy,
        output tx_full,
        output fifo_level,
        output tx_overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. Bytes strobed in on tx_send/tx_data
// are queued in a circular FIFO and sent 8N1, LSB first, on uart_tx.
// CLK_MHZ=0 selects a fast mode with one clock per bit.
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit between
// the last data bit and the stop bit (11-bit frame instead of 10).
module uart_tx_fifo #(
    parameter int CLK_MHZ    = 12,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus
);
    localparam int CPB_RAW = (CLK_MHZ * 1000000) / BAUD;
    localparam int CPB     = (CLK_MHZ == 0 || CPB_RAW < 1) ? 1 : CPB_RAW;
    localparam int CNT_W   = $clog2(CPB + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CPB - 1);
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               tx_q;
    logic               tx_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [2:0]         bit_q;
    logic [2:0]         bit_d;
    logic [7:0]         byte_q;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] level;
    logic               overflow;

    logic               pop;
    logic               full;
    logic               wr_en;
    logic               bit_end;

    // A write is accepted unless the queue is full and nothing leaves it this cycle.
    assign full    = (level == LEVEL_FULL);
    assign wr_en   = bus.tx_send && (!full || pop);
    assign bit_end = (cnt_q == CNT_LAST);

    // Next-state, next line level and bit-period counting for the frame sequencer.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (level != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    tx_d    = byte_q[0];
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = ^byte_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = byte_q[bit_d];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                cnt_d   = '0;
            end
        endcase
    end

    // Sequencer registers; the line itself is a flop so uart_tx never glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            if (pop) begin
                byte_q <= mem[rd_ptr];
            end
        end
    end

    // Storage array; holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= bus.tx_data;
        end
    end

    // Queue pointers, occupancy and the sticky dropped-write flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (wr_en && !pop) begin
                level <= level + LEVEL_W'(1);
            end else if (!wr_en && pop) begin
                level <= level - LEVEL_W'(1);
            end
            if (bus.tx_send && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.uart_tx     = tx_q;
    assign bus.tx_busy     = (state_q != S_IDLE) || (level != '0);
    assign bus.tx_full     = full;
    assign bus.fifo_level  = level;
    assign bus.tx_overflow = overflow;
endmodule
